// File: rtl/scene_fb_pkg.sv
// Shared constants, opcodes and state encoding for the scene frame-buffer writer.
package scene_fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_PIXELS = 76800;
    localparam int FB_ADDR_W = 17;
    localparam int COLOR_W   = 12;

    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_BLIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BLIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fb_state_e;

endpackage

// File: rtl/scene_fb_raster_cnt.sv
// Row-major raster counter: load a w x h window, step one pixel at a time, flag the last pixel.
module scene_fb_raster_cnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [8:0] w_i,
    input  logic [7:0] h_i,
    output logic [8:0] col_o,
    output logic [7:0] row_o,
    output logic       last_o
);

    logic [8:0] col_q, col_d, w_q;
    logic [7:0] row_q, row_d, h_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            col_d = 9'd0;
            row_d = 8'd0;
        end else if (step_i) begin
            if (col_q == w_q - 9'd1) begin
                col_d = 9'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end else begin
            col_d = col_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= 9'd0;
            row_q <= 8'd0;
            w_q   <= 9'd0;
            h_q   <= 8'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (load_i) begin
                w_q <= w_i;
                h_q <= h_i;
            end
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == w_q - 9'd1) && (row_q == h_q - 8'd1);

endmodule

// File: rtl/scene_fb_writer.sv
// Frame-buffer writer: CLEAR fills the buffer, BLIT copies a clipped sprite rectangle.
// Optional BLIT_TRANSPARENT_EN suppresses writes of the TRANSPARENT colour key.
module scene_fb_writer
    import scene_fb_pkg::*;
#(
    parameter int                 WIDTH       = FB_WIDTH,
    parameter int                 HEIGHT      = FB_HEIGHT,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_op_i,
    input  logic [8:0]  cmd_x_i,
    input  logic [7:0]  cmd_y_i,
    input  logic [8:0]  cmd_w_i,
    input  logic [7:0]  cmd_h_i,
    input  logic [16:0] cmd_src_base_i,
    input  logic [11:0] cmd_color_i,
    output logic [16:0] src_addr_o,
    input  logic [11:0] src_data_i,
    output logic        fb_we_o,
    output logic [16:0] fb_addr_o,
    output logic [11:0] fb_wdata_o,
    output logic        busy_o,
    output logic        done_o
);

`ifdef BLIT_TRANSPARENT_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    fb_state_e   state_q;
    logic        cmd_ready_q, done_q, fb_we_q;
    logic [16:0] fb_addr_q, src_addr_q, s1_addr_q;
    logic [11:0] fb_wdata_q;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [1:0]  drain_q;
    logic        s1_valid_q, s1_inb_q;

    logic        accept_s, cnt_step_s, cnt_last_s, inb_s, opaque_s;
    logic [8:0]  cnt_col_s, cnt_w_s;
    logic [7:0]  cnt_row_s, cnt_h_s;
    logic [9:0]  col_sum_s;
    logic [8:0]  row_sum_s;
    logic [16:0] dest_s;

    assign accept_s   = cmd_valid_i && cmd_ready_q;
    assign cnt_w_s    = (cmd_op_i == OP_CLEAR) ? 9'(WIDTH)  : cmd_w_i;
    assign cnt_h_s    = (cmd_op_i == OP_CLEAR) ? 8'(HEIGHT) : cmd_h_i;
    assign cnt_step_s = ((state_q == ST_CLEAR) || (state_q == ST_BLIT)) && !cnt_last_s;

    scene_fb_raster_cnt u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (accept_s),
        .step_i (cnt_step_s),
        .w_i    (cnt_w_s),
        .h_i    (cnt_h_s),
        .col_o  (cnt_col_s),
        .row_o  (cnt_row_s),
        .last_o (cnt_last_s)
    );

    // Widened sums keep off-screen destinations from aliasing back on-screen.
    assign col_sum_s = {1'b0, x_q} + {1'b0, cnt_col_s};
    assign row_sum_s = {1'b0, y_q} + {1'b0, cnt_row_s};
    assign inb_s     = (col_sum_s < 10'(WIDTH)) && (row_sum_s < 9'(HEIGHT));
    assign dest_s    = 17'(row_sum_s) * 17'(WIDTH) + 17'(col_sum_s);
    assign opaque_s  = !(KEY_EN && (src_data_i == TRANSPARENT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= 17'd0;
            fb_wdata_q  <= 12'd0;
            src_addr_q  <= 17'd0;
            x_q         <= 9'd0;
            y_q         <= 8'd0;
            drain_q     <= 2'd0;
            s1_valid_q  <= 1'b0;
            s1_inb_q    <= 1'b0;
            s1_addr_q   <= 17'd0;
        end else begin
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            // Write stage: the ROM word for the stage-1 pixel arrives this cycle.
            fb_we_q    <= s1_valid_q && s1_inb_q && opaque_s;
            if (s1_valid_q) begin
                fb_addr_q  <= s1_addr_q;
                fb_wdata_q <= src_data_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_q <= 1'b0;
                        x_q         <= cmd_x_i;
                        y_q         <= cmd_y_i;
                        if (cmd_op_i == OP_CLEAR) begin
                            state_q    <= ST_CLEAR;
                            fb_we_q    <= 1'b1;
                            fb_addr_q  <= 17'd0;
                            fb_wdata_q <= cmd_color_i;
                        end else if ((cmd_w_i == 9'd0) || (cmd_h_i == 8'd0)) begin
                            state_q <= ST_DRAIN;
                            drain_q <= 2'd0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_BLIT;
                            src_addr_q <= cmd_src_base_i;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (cnt_last_s) begin
                        fb_we_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DRAIN;
                        drain_q <= 2'd0;
                    end else begin
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= fb_addr_q + 17'd1;
                    end
                end
                ST_BLIT: begin
                    s1_valid_q <= 1'b1;
                    s1_inb_q   <= inb_s;
                    s1_addr_q  <= dest_s;
                    if (cnt_last_s) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 2'd2;
                    end else begin
                        src_addr_q <= src_addr_q + 17'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 2'd0) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        if (drain_q == 2'd1) begin
                            done_q <= 1'b1;
                        end
                        drain_q <= drain_q - 2'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = !cmd_ready_q;
    assign done_o      = done_q;
    assign fb_we_o     = fb_we_q;
    assign fb_addr_o   = fb_addr_q;
    assign fb_wdata_o  = fb_wdata_q;
    assign src_addr_o  = src_addr_q;

endmodule

// File: doc/scene_fb_writer.md
Name: scene_fb_writer

Overview:
Writer side of the 320x240, 12-bit RGB scene frame buffer that the scene renderers read through pixel_addr. It accepts draw commands over a valid/ready handshake and writes the buffer's write port one pixel per cycle. Supported operations are CLEAR (fill the whole buffer with one colour) and BLIT (copy a w x h rectangle from a sprite ROM to (x,y), with clipping). It sits between game logic and the frame-buffer BRAM write port.

Parameters:
WIDTH, 320, frame buffer width in pixels
HEIGHT, 240, frame buffer height in pixels
TRANSPARENT, 12'hF0F, sprite colour key skipped when BLIT_TRANSPARENT_EN is defined

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready
cmd_op  in  1  0 = CLEAR, 1 = BLIT
cmd_x  in  9  BLIT destination column
cmd_y  in  8  BLIT destination row
cmd_w  in  9  BLIT width
cmd_h  in  8  BLIT height
cmd_src_base  in  17  sprite ROM base address
cmd_color  in  12  CLEAR fill colour
src_addr  out  17  sprite ROM read address; synchronous ROM, 1-cycle latency
src_data  in  12  sprite ROM read data
fb_we  out  1  frame buffer write enable
fb_addr  out  17  frame buffer write address = y*WIDTH + x
fb_wdata  out  12  frame buffer write data
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values: cmd_ready=1 and busy=0 (state IDLE); fb_we=0, fb_addr=0, fb_wdata=0, src_addr=0, done=0.
- Reset mid-command aborts the command: fb_we is 0 from the next edge and the state returns to IDLE. There is no partial-completion done pulse.
- States: IDLE, CLEAR, BLIT, DRAIN.
- cmd_ready=1 only in IDLE. busy = !cmd_ready. Command fields are registered on acceptance; input changes after acceptance are ignored.
- CLEAR, accepted at cycle T:
  - fb_we=1 in cycles T+1 .. T+76800.
  - fb_addr runs 0..76799 sequentially; fb_wdata=cmd_color.
  - done pulses at T+76801, then the state returns to IDLE.
- BLIT, accepted at cycle T; N = w*h; pixel i has row r = i/w and col c = i%w, scanned row-major:
  - src_addr = src_base + i, driven in cycle T+1+i (17-bit wrap).
  - src_data is valid at T+2+i.
  - Registered write in cycle T+3+i: fb_addr = (y+r)*WIDTH + (x+c), fb_wdata = src_data.
  - Throughput is one pixel per cycle.
  - After the last src_addr the state moves to DRAIN for 2 cycles; done pulses at T+3+N.
- Clipping: a pixel with x+c >= WIDTH or y+r >= HEIGHT still consumes its cycle but gets fb_we=0. There is no wrap to the next row.
- Destination arithmetic uses 10-bit column and 9-bit row sums to avoid overflow. The product is 17 bits, and the maximum address is 76799.
- w=0 or h=0: no src reads and no writes. done pulses at T+1, and the block is back in IDLE (cmd_ready=1) at T+2.
- cmd_valid in the same cycle done pulses is not accepted, because cmd_ready is still 0. It is accepted the following cycle.
- Row/col counters are internal and not exported.

Optional Feature:
BLIT_TRANSPARENT_EN
- Defined: a BLIT pixel whose src_data == TRANSPARENT gets fb_we=0 in its write cycle. Timing and done are unchanged.
- Undefined: every in-bounds pixel is written. CLEAR is unaffected in both cases.

Decomposition:
- Package scene_fb_pkg holds:
  - constants FB_WIDTH=320, FB_HEIGHT=240, FB_PIXELS=76800, FB_ADDR_W=17, COLOR_W=12;
  - opcode constants OP_CLEAR=0, OP_BLIT=1;
  - the state encoding typedef.
- One sub-module, scene_fb_raster_cnt: row/col counter with load, step and last-pixel flag, reused by CLEAR (as a 320x240 scan) and BLIT (as a w x h scan).

Test Plan:
- Reset is held 3 cycles, then released: cmd_ready=1, fb_we=0, done=0. Reset asserted mid-CLEAR at pixel 100: fb_we=0 on the next edge, no done pulse, cmd_ready=1.
- CLEAR with color=12'h00D: exactly 76800 writes, addresses 0..76799, data 00D; done pulses one cycle after the last write; cmd_ready returns to 1.
- BLIT x=10, y=20, w=4, h=2, src_base=100, ROM[a]=a[11:0]:
  - writes go to addresses 6410..6413 with data 100..103, and 6730..6733 with data 104..107;
  - first fb_we is 3 cycles after acceptance; done pulses at T+11.
- BLIT x=318, y=239, w=4, h=2: only addresses 76798 and 76799 are written; 8 src reads are still issued; done pulses at T+11.
- BLIT w=0: no fb_we and no src_addr activity; done pulses at T+1. A back-to-back cmd_valid is accepted exactly at T+2.
- With BLIT_TRANSPARENT_EN, BLIT w=3, h=1 with ROM data {F0F, 123, F0F}: a single write, data 123 at the middle address. Without the macro, 3 writes.
